// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helpers,
// also used by the transmitter side.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit. Callers must pick CLK_FREQ/UART_BPS so that this is at least 8.
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int half_bit(input int clk_freq, input int uart_bps);
    return baud_cnt_max(clk_freq, uart_bps) / 2;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side link bundle: serial pin in, recovered byte and status pulses out.
interface uart_rx_frame_if;
    logic       uart_rxd;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_rx_frame_err;
    logic       uart_rx_busy;

    modport master (
        output uart_rxd,
        input  uart_rx_data,
        input  uart_rx_done,
        input  uart_rx_frame_err,
        input  uart_rx_busy
    );

    modport slave (
        input  uart_rxd,
        output uart_rx_data,
        output uart_rx_done,
        output uart_rx_frame_err,
        output uart_rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rxd pin into the clk domain and flags its falling edges.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic fall_pulse
);
    logic rxd_meta;
    logic rxd_d;

    // NOTE: flops reset to 1 (the idle line level) so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    assign fall_pulse = rxd_d & ~rxd_s;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: start-edge detect, 3-sample majority vote per bit,
// false-start rejection and framing-error reporting.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int UART_BPS = 115200
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_frame_if.slave  rx
);
    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int HALF         = half_bit(CLK_FREQ, UART_BPS);

    localparam logic [15:0] CNT_LAST = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] SAMP_0   = 16'(HALF - 1);
    localparam logic [15:0] SAMP_1   = 16'(HALF);
    localparam logic [15:0] DECIDE   = 16'(HALF + 1);

    logic        rxd_s;
    logic        fall_pulse;

    rx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  samp;
    logic [7:0]  shreg;
    logic [7:0]  data_q;
    logic        done_q;
    logic        err_q;
    logic        busy_q;

    logic        wrap;
    logic        decide;
    logic        vote;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rx.uart_rxd),
        .rxd_s      (rxd_s),
        .fall_pulse (fall_pulse)
    );

    assign wrap   = (baud_cnt == CNT_LAST);
    assign decide = (baud_cnt == DECIDE);
    // Third sample is taken live at the decision count; the first two were latched earlier.
    assign vote   = majority3(samp[0], samp[1], rxd_s);

    // NOTE: all state here is sequential and updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            samp     <= 2'b11;
            shreg    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (state != IDLE) begin
                baud_cnt <= wrap ? '0 : baud_cnt + 16'd1;
                if (baud_cnt == SAMP_0) samp[0] <= rxd_s;
                if (baud_cnt == SAMP_1) samp[1] <= rxd_s;
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fall_pulse) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end

                START: begin
                    if (decide && vote) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (wrap) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end

                DATA: begin
                    if (decide) shreg[bit_cnt] <= vote;
                    if (wrap) begin
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                end

                STOP: begin
                    // Leave at mid-stop so a following start edge half a bit later is seen.
                    if (decide) begin
                        if (vote) begin
                            data_q <= shreg;
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rx.uart_rx_data      = data_q;
    assign rx.uart_rx_done      = done_q;
    assign rx.uart_rx_frame_err = err_q;
    assign rx.uart_rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: serial frames from a bit-level driver
// are compared against a byte-level reference model (expected bytes and arrival window).
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BMAX     = CLK_FREQ / UART_BPS;
    localparam int HALF     = BMAX / 2;
    // Negedge-to-negedge count from the pin falling to done first seen high.
    localparam int LAT_NOM  = 9 * BMAX + HALF + 4;

    typedef struct {
        logic [7:0] data;
        int         fall;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] last_good = 8'h00;
    int         err_cnt   = 0;
    int         both_cnt  = 0;

    uart_rx_frame_if rx_if ();

    uart_rx_frame #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_if.uart_rx_done) begin
                got_q.push_back(rx_if.uart_rx_data);
                got_cyc.push_back(cyc);
            end
            if (rx_if.uart_rx_frame_err) err_cnt <= err_cnt + 1;
            if (rx_if.uart_rx_done && rx_if.uart_rx_frame_err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_if.uart_rxd = 1'b1;
        end
    endtask

    // Drives one frame; glitch[b] inverts bit b (0=start, 9=stop) for one clk at HALF.
    // abort_bit >= 0 pulls rst_n low mid-bit and returns immediately.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic [9:0] glitch, input int abort_bit);
        logic [9:0] bits;
        int         fall;
        bits = {stop, data, 1'b0};
        fall = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BMAX; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) fall = cyc;
                if (b == abort_bit && c == HALF) begin
                    rst_n          = 1'b0;
                    rx_if.uart_rxd = 1'b1;
                    last_good      = 8'h00;
                    return;
                end
                rx_if.uart_rxd = bits[b] ^ (glitch[b] && c == HALF);
            end
        end
        if (stop) begin
            exp_q.push_back('{data: data, fall: fall});
            last_good = data;
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        rx_if.uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (rx_if.uart_rx_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_data got=%h want=00", rx_if.uart_rx_data);
        end
        if (rx_if.uart_rx_done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done got=%b want=0", rx_if.uart_rx_done);
        end
        if (rx_if.uart_rx_frame_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err got=%b want=0", rx_if.uart_rx_frame_err);
        end
        if (rx_if.uart_rx_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got=%b want=0", rx_if.uart_rx_busy);
        end
        rst_n = 1'b1;
        idle(2 * BMAX);
    endtask

    task automatic test_single();
        int e0;
        e0 = err_cnt;
        send_frame(8'h55, 1'b1, '0, -1);
        idle(2 * BMAX);
        n_cmp += 3;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL single_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [7:0] g = got_q.pop_front();
            int lat = got_cyc.pop_front() - e.fall;
            n_cmp += 2;
            if (g !== e.data) begin
                n_bad++; $display("FAIL single_data got=%h want=%h", g, e.data);
            end
            if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                n_bad++; $display("FAIL single_latency got=%0d want=%0d+-1", lat, LAT_NOM);
            end
        end
        if (err_cnt != e0) begin
            n_bad++; $display("FAIL single_err got=%0d want=%0d", err_cnt, e0);
        end
        if (rx_if.uart_rx_busy !== 1'b0) begin
            n_bad++; $display("FAIL single_busy got=%b want=0", rx_if.uart_rx_busy);
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = err_cnt;
        send_frame(8'hA3, 1'b1, '0, -1);
        send_frame(8'h00, 1'b1, '0, -1);
        send_frame(8'hFF, 1'b1, '0, -1);
        idle(2 * BMAX);
        n_cmp += 2;
        if (got_q.size() != 3) begin
            n_bad++; $display("FAIL b2b_count got=%0d want=3", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [7:0] g = got_q.pop_front();
            int lat = got_cyc.pop_front() - e.fall;
            n_cmp += 2;
            if (g !== e.data) begin
                n_bad++; $display("FAIL b2b_data got=%h want=%h", g, e.data);
            end
            if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                n_bad++; $display("FAIL b2b_latency got=%0d want=%0d+-1", lat, LAT_NOM);
            end
        end
        if (err_cnt != e0) begin
            n_bad++; $display("FAIL b2b_err got=%0d want=%0d", err_cnt, e0);
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_false_start();
        int   e0;
        logic saw_busy;
        e0       = err_cnt;
        saw_busy = 1'b0;
        @(negedge clk);
        rx_if.uart_rxd = 1'b0;
        for (int i = 1; i <= BMAX + 4; i++) begin
            @(negedge clk);
            if (i == 3) rx_if.uart_rxd = 1'b1;
            if (rx_if.uart_rx_busy) saw_busy = 1'b1;
        end
        n_cmp += 4;
        if (saw_busy !== 1'b1) begin
            n_bad++; $display("FAIL false_start_busy_seen got=%b want=1", saw_busy);
        end
        if (rx_if.uart_rx_busy !== 1'b0) begin
            n_bad++; $display("FAIL false_start_busy_low got=%b want=0", rx_if.uart_rx_busy);
        end
        idle(2 * BMAX);
        if (got_q.size() != 0) begin
            n_bad++; $display("FAIL false_start_done got=%0d want=0", got_q.size());
        end
        if (err_cnt != e0) begin
            n_bad++; $display("FAIL false_start_err got=%0d want=%0d", err_cnt, e0);
        end
        got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_frame_err();
        int         e0;
        logic [7:0] prev;
        e0   = err_cnt;
        prev = last_good;
        send_frame(8'h3C, 1'b0, '0, -1);
        // Hold the line low (break) for two more bits before it returns high.
        repeat (2 * BMAX) @(negedge clk);
        idle(2 * BMAX);
        n_cmp += 3;
        if (err_cnt != e0 + 1) begin
            n_bad++; $display("FAIL ferr_count got=%0d want=%0d", err_cnt, e0 + 1);
        end
        if (got_q.size() != 0) begin
            n_bad++; $display("FAIL ferr_done got=%0d want=0", got_q.size());
        end
        if (rx_if.uart_rx_data !== prev) begin
            n_bad++; $display("FAIL ferr_data_held got=%h want=%h", rx_if.uart_rx_data, prev);
        end
        send_frame(8'h81, 1'b1, '0, -1);
        idle(2 * BMAX);
        n_cmp += 2;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL ferr_recover_count got=%0d want=1", got_q.size());
        end
        if (rx_if.uart_rx_data !== 8'h81) begin
            n_bad++; $display("FAIL ferr_recover_data got=%h want=81", rx_if.uart_rx_data);
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_cnt;
        // Data bits 2 and 6 sit at frame positions 3 and 7.
        send_frame(8'h0F, 1'b1, 10'b00_1000_1000, -1);
        idle(2 * BMAX);
        n_cmp += 3;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL glitch_count got=%0d want=1", got_q.size());
        end
        if (rx_if.uart_rx_data !== 8'h0F) begin
            n_bad++; $display("FAIL glitch_data got=%h want=0f", rx_if.uart_rx_data);
        end
        if (err_cnt != e0) begin
            n_bad++; $display("FAIL glitch_err got=%0d want=%0d", err_cnt, e0);
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reset_mid();
        int e0;
        send_frame(8'hE7, 1'b1, '0, 5);
        #1;
        n_cmp += 2;
        if (rx_if.uart_rx_data !== 8'h00) begin
            n_bad++; $display("FAIL midrst_data got=%h want=00", rx_if.uart_rx_data);
        end
        if (rx_if.uart_rx_busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_busy got=%b want=0", rx_if.uart_rx_busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0    = err_cnt;
        idle(2 * BMAX);
        send_frame(8'h5A, 1'b1, '0, -1);
        idle(2 * BMAX);
        n_cmp += 3;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL midrst_count got=%0d want=1", got_q.size());
        end
        if (rx_if.uart_rx_data !== 8'h5A) begin
            n_bad++; $display("FAIL midrst_next_data got=%h want=5a", rx_if.uart_rx_data);
        end
        if (err_cnt != e0) begin
            n_bad++; $display("FAIL midrst_err got=%0d want=%0d", err_cnt, e0);
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_random();
        int e0;
        int n_err_exp;
        e0        = err_cnt;
        n_err_exp = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, s, '0, -1);
            if (!s) begin
                n_err_exp++;
                idle(BMAX + $urandom_range(0, BMAX));
            end else begin
                idle($urandom_range(0, 2 * BMAX));
            end
        end
        idle(2 * BMAX);
        n_cmp += 2;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        if (err_cnt != e0 + n_err_exp) begin
            n_bad++; $display("FAIL rand_err got=%0d want=%0d", err_cnt, e0 + n_err_exp);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [7:0] g = got_q.pop_front();
            int lat = got_cyc.pop_front() - e.fall;
            n_cmp += 2;
            if (g !== e.data) begin
                n_bad++; $display("FAIL rand_data got=%h want=%h", g, e.data);
            end
            if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                n_bad++; $display("FAIL rand_latency got=%0d want=%0d+-1", lat, LAT_NOM);
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (both_cnt != 0) begin
            n_bad++; $display("FAIL done_err_overlap got=%0d want=0", both_cnt);
        end
    endtask

    initial begin
        rx_if.uart_rxd = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receive path: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from the asynchronous `uart_rxd` pin.
- Presents each byte as a one-cycle `uart_rx_done` pulse with the data held stable until the next good frame.
- Pairs with the existing UART transmitter at the same `CLK_FREQ`/`UART_BPS`, forming the host-link receive side.
- Adds majority-vote sampling, false-start rejection and framing-error reporting.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate in bit/s
- BAUD_CNT_MAX, CLK_FREQ/UART_BPS (localparam), clocks per bit; must be ≥8
- HALF, BAUD_CNT_MAX/2 (localparam), mid-bit count

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- uart_rxd  input  1  asynchronous serial line, idle high
- uart_rx_data  output  8  last correctly framed byte
- uart_rx_done  output  1  one-cycle pulse: `uart_rx_data` updated this cycle
- uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- uart_rx_busy  output  1  high while a frame is in progress (state ≠ IDLE)

Behaviour:
- Reset values:
  - Sync flops = 1.
  - `uart_rx_data` = 8'h00; `uart_rx_done`, `uart_rx_frame_err`, `uart_rx_busy` = 0.
  - state = IDLE; `baud_cnt` = 0; `bit_cnt` = 0.
- Input conditioning:
  - 2-FF synchronizer on `uart_rxd`, plus a third flop for edge detect.
  - Start detect = synced value 1→0 (falling edge only). A line held low never retriggers.
- Baud counter:
  - 16-bit, counts 0..BAUD_CNT_MAX-1 and wraps while state ≠ IDLE.
  - Cleared to 0 on entering START.
- Sampling: in every bit, take synced line at `baud_cnt` = HALF-1, HALF, HALF+1. The bit value is the majority of the 3, decided at HALF+1.
- State machine:
  - IDLE: on falling edge → START, `busy`=1 next cycle.
  - START: at decision point, voted 1 (false start/glitch) → IDLE, no outputs pulsed. Voted 0 → continue. At `baud_cnt` wrap → DATA, `bit_cnt`=0.
  - DATA: at each decision, shift the voted bit into shift register position `bit_cnt` (LSB first). At wrap, `bit_cnt`+1; after `bit_cnt`=7 wraps → STOP.
  - STOP: at decision point:
    - Voted 1 → next cycle `uart_rx_data` ← shift register, `uart_rx_done`=1 for exactly 1 cycle.
    - Voted 0 → `uart_rx_frame_err`=1 for 1 cycle; `uart_rx_data` unchanged.
    - Either way → IDLE immediately (does not wait for end of stop bit), so a back-to-back start edge half a bit later is caught.
- `uart_rx_done` and `uart_rx_frame_err` are never high in the same cycle, and never high outside STOP exit.
- Latency: `done` rises 9·BAUD_CNT_MAX + HALF + 2..5 clk after the pin falling edge (sync/edge pipeline included). The bench checks a ±1 clk window around the value computed from its chosen parameters.
- Frame error followed by a low line (break): stays IDLE until the line returns high and falls again.
- `rst_n` asserted mid-frame: all state returns to reset values asynchronously; the partial byte is lost. After release, the first frame is accepted only on a fresh falling edge.
- No flow control: the consumer must take data on `done`. A new good frame overwrites `uart_rx_data`.

Decomposition:
- Shared package `uart_pkg`: state encoding constants (IDLE, START, DATA, STOP, 2-bit) and the BAUD_CNT_MAX/HALF derivation, reused by transmitter-side updates.
- Sub-module `uart_rx_sync`: 2-FF synchronizer + edge-detect flop; outputs `rxd_s` and `fall_pulse`.
- FSM, counters, majority vote and output registers stay in `uart_rx_frame`.

Test Plan:
All scenarios use CLK_FREQ=1000000, UART_BPS=100000 (BAUD_CNT_MAX=10, HALF=5).
- Single frame 0x55, correct stop → one `done` pulse; `uart_rx_data`=8'h55; `frame_err` never high; `busy` low after.
- Back-to-back frames 0xA3 then 0x00, then 0xFF (no idle gap) → three `done` pulses with data A3, 00, FF in order; no errors.
- Line low for 3 clk, then high → no `done`, no `frame_err`; `busy` returns low within BAUD_CNT_MAX+4 clk.
- Frame 0x3C with stop bit driven 0 → one `frame_err` pulse, no `done`; `uart_rx_data` keeps its prior value. Then 0x81 sent after the line is high ≥1 bit → `done`, data 81.
- Frame 0x0F with a 1-clk inverted glitch at HALF in bit 2 and bit 6 → majority vote rejects it; `done`, data 0F.
- `rst_n` pulsed low during bit 4 of frame 0xE7 → all outputs reset immediately. The next clean frame 0x5A → `done`, data 5A, with no spurious pulse from the aborted frame.
